stpw_ctrl: RTL and testbench

- Control unit for the stopwatch datapath. Generates the datapath's `run` and `clr` inputs from two command sources: debounced button pulses and UART RX command bytes.
- Arbitrates between the two sources in the same cycle.
- Optionally captures a lap snapshot of the running time.
- Sits between the button/UART front-end and the stopwatch datapath in the dual-watch top.

---
 rtl/stpw_pkg.sv | 32 +++
 rtl/stpw_ctrl_if.sv | 37 +++
 rtl/stpw_cmd_decode.sv | 37 +++
 rtl/stpw_ctrl.sv | 148 ++++++++++++++
 tb/tb_stpw_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/stpw_pkg.sv
// Shared types and constants for the stopwatch control unit.
package stpw_pkg;

  // FSM state codes; 2'd3 is unused and recovers to ST_STOP.
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Command after decode/arbitration.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_RUNSTOP,
    CMD_CLEAR,
    CMD_LAP
  } cmd_e;

  // Default ASCII command characters (uppercase form).
  localparam logic [7:0] CH_RUN_DEF = 8'h52;  // 'R'
  localparam logic [7:0] CH_CLR_DEF = 8'h43;  // 'C'
  localparam logic [7:0] CH_LAP_DEF = 8'h4C;  // 'L'

  // Setting bit 5 turns an uppercase ASCII letter into its lowercase form.
  localparam logic [7:0] CASE_BIT = 8'h20;

  // True when a byte is either case of the command character.
  function automatic logic ch_match(input logic [7:0] b, input logic [7:0] ch);
    return (b == ch) || (b == (ch | CASE_BIT));
  endfunction

endpackage

// File: rtl/stpw_ctrl_if.sv
// Command/status bundle between the front-end and the stopwatch control unit.
interface stpw_ctrl_if;
  logic       i_btn_runstop;
  logic       i_btn_clear;
  logic       i_rx_valid;
  logic [7:0] i_rx_data;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic [5:0] i_min;
  logic [4:0] i_hour;
  logic       o_run;
  logic       o_clr;
  logic [1:0] o_state;
  logic       o_cmd_err;
  logic       o_cmd_drop;
  logic       o_lap_valid;
  logic [6:0] o_lap_msec;
  logic [5:0] o_lap_sec;
  logic [5:0] o_lap_min;
  logic [4:0] o_lap_hour;

  // Control unit side.
  modport slave (
    input  i_btn_runstop, i_btn_clear, i_rx_valid, i_rx_data,
    input  i_msec, i_sec, i_min, i_hour,
    output o_run, o_clr, o_state, o_cmd_err, o_cmd_drop,
    output o_lap_valid, o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour
  );

  // Front-end / datapath side.
  modport master (
    output i_btn_runstop, i_btn_clear, i_rx_valid, i_rx_data,
    output i_msec, i_sec, i_min, i_hour,
    input  o_run, o_clr, o_state, o_cmd_err, o_cmd_drop,
    input  o_lap_valid, o_lap_msec, o_lap_sec, o_lap_min, o_lap_hour
  );
endinterface

// File: rtl/stpw_cmd_decode.sv
// Combinational UART byte to command decode. Case-insensitive.
// Build option STPW_LAP_EN: when undefined, the lap character is unrecognised.
module stpw_cmd_decode
  import stpw_pkg::*;
#(
  parameter logic [7:0] CH_RUN = CH_RUN_DEF,
  parameter logic [7:0] CH_CLR = CH_CLR_DEF,
  parameter logic [7:0] CH_LAP = CH_LAP_DEF
) (
  input  logic [7:0] data_i,
  output cmd_e       cmd_o,
  output logic       err_o
);

`ifndef STPW_LAP_EN
  logic unused_ch_lap;
  assign unused_ch_lap = ^CH_LAP;
`endif

  // Map byte to command; anything else flags an error.
  always_comb begin
    cmd_o = CMD_NONE;
    err_o = 1'b0;
    if (ch_match(data_i, CH_RUN)) begin
      cmd_o = CMD_RUNSTOP;
    end else if (ch_match(data_i, CH_CLR)) begin
      cmd_o = CMD_CLEAR;
`ifdef STPW_LAP_EN
    end else if (ch_match(data_i, CH_LAP)) begin
      cmd_o = CMD_LAP;
`endif
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/stpw_ctrl.sv
// Stopwatch control unit: arbitrates button and UART commands, drives the
// datapath run/clr controls and optionally captures lap snapshots.
// Build option STPW_LAP_EN enables lap capture.
module stpw_ctrl
  import stpw_pkg::*;
#(
  parameter logic [7:0] CH_RUN = CH_RUN_DEF,
  parameter logic [7:0] CH_CLR = CH_CLR_DEF,
  parameter logic [7:0] CH_LAP = CH_LAP_DEF
) (
  input logic        clk,
  input logic        rst,
  stpw_ctrl_if.slave ctrl_io
);

  cmd_e   dec_cmd;
  logic   dec_err;
  cmd_e   cmd_sel;
  logic   err_d, drop_d;
  state_e state_q;
  logic   run_q, clr_q, cmd_err_q, cmd_drop_q;

  stpw_cmd_decode #(
    .CH_RUN (CH_RUN),
    .CH_CLR (CH_CLR),
    .CH_LAP (CH_LAP)
  ) u_decode (
    .data_i (ctrl_io.i_rx_data),
    .cmd_o  (dec_cmd),
    .err_o  (dec_err)
  );

  // Arbitration: buttons beat UART; both buttons mean clear; the clear cycle
  // swallows every command without reporting anything.
  always_comb begin
    cmd_sel = CMD_NONE;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    if (ctrl_io.i_btn_runstop || ctrl_io.i_btn_clear) begin
      cmd_sel = ctrl_io.i_btn_clear ? CMD_CLEAR : CMD_RUNSTOP;
      drop_d  = ctrl_io.i_rx_valid;
    end else if (ctrl_io.i_rx_valid) begin
      cmd_sel = dec_cmd;
      err_d   = dec_err;
    end
    if (state_q == ST_CLEAR) begin
      cmd_sel = CMD_NONE;
      err_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

`ifdef STPW_LAP_EN
  logic       lap_valid_q;
  logic [6:0] lap_msec_q;
  logic [5:0] lap_sec_q;
  logic [5:0] lap_min_q;
  logic [4:0] lap_hour_q;
`else
  logic unused_time;
  assign unused_time = ^{ctrl_io.i_msec, ctrl_io.i_sec, ctrl_io.i_min, ctrl_io.i_hour};
`endif

  // FSM with registered Moore outputs, status pulses and lap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_STOP;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      cmd_err_q  <= 1'b0;
      cmd_drop_q <= 1'b0;
`ifdef STPW_LAP_EN
      lap_valid_q <= 1'b0;
      lap_msec_q  <= '0;
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_hour_q  <= '0;
`endif
    end else begin
      cmd_err_q  <= err_d;
      cmd_drop_q <= drop_d;
`ifdef STPW_LAP_EN
      lap_valid_q <= 1'b0;
`endif
      case (state_q)
        ST_STOP: begin
          if (cmd_sel == CMD_RUNSTOP) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else if (cmd_sel == CMD_CLEAR) begin
            state_q <= ST_CLEAR;
            clr_q   <= 1'b1;
`ifdef STPW_LAP_EN
            lap_msec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            lap_hour_q <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (cmd_sel == CMD_RUNSTOP) begin
            state_q <= ST_STOP;
            run_q   <= 1'b0;
`ifdef STPW_LAP_EN
          end else if (cmd_sel == CMD_LAP) begin
            lap_valid_q <= 1'b1;
            lap_msec_q  <= ctrl_io.i_msec;
            lap_sec_q   <= ctrl_io.i_sec;
            lap_min_q   <= ctrl_io.i_min;
            lap_hour_q  <= ctrl_io.i_hour;
`endif
          end
        end
        ST_CLEAR: begin
          state_q <= ST_STOP;
          clr_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_STOP;
          run_q   <= 1'b0;
          clr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_io.o_run      = run_q;
  assign ctrl_io.o_clr      = clr_q;
  assign ctrl_io.o_state    = state_q;
  assign ctrl_io.o_cmd_err  = cmd_err_q;
  assign ctrl_io.o_cmd_drop = cmd_drop_q;

`ifdef STPW_LAP_EN
  assign ctrl_io.o_lap_valid = lap_valid_q;
  assign ctrl_io.o_lap_msec  = lap_msec_q;
  assign ctrl_io.o_lap_sec   = lap_sec_q;
  assign ctrl_io.o_lap_min   = lap_min_q;
  assign ctrl_io.o_lap_hour  = lap_hour_q;
`else
  assign ctrl_io.o_lap_valid = 1'b0;
  assign ctrl_io.o_lap_msec  = '0;
  assign ctrl_io.o_lap_sec   = '0;
  assign ctrl_io.o_lap_min   = '0;
  assign ctrl_io.o_lap_hour  = '0;
`endif

endmodule

// File: tb/tb_stpw_ctrl.sv
// Scoreboard bench for stpw_ctrl: the driver pushes the outputs expected one
// cycle later from a behavioural model; a negedge monitor pops and compares.
module tb_stpw_ctrl;

`ifdef STPW_LAP_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  typedef struct packed {
    logic       run;
    logic       clr;
    logic [1:0] state;
    logic       err;
    logic       drop;
    logic       lapv;
    logic [6:0] ms;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
  } obs_t;

  typedef struct {
    int   due;
    obs_t exp;
  } sb_t;

  logic clk;
  logic rst;
  stpw_ctrl_if bus ();

  stpw_ctrl u_dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  pcount   = 0;
  int  ncyc     = 0;

  // Model: 0 = stopped, 1 = running, 2 = clearing; plus latched lap time.
  int         m_state = 0;
  logic [6:0] m_ms = '0;
  logic [5:0] m_s = '0;
  logic [5:0] m_m = '0;
  logic [4:0] m_h = '0;

  // Time values presented to the DUT on the next step.
  logic [6:0] t_ms = '0;
  logic [5:0] t_s = '0;
  logic [5:0] t_m = '0;
  logic [4:0] t_h = '0;

  task automatic step(input bit r, input bit rs, input bit cl, input bit rxv,
                      input logic [7:0] d);
    obs_t       e;
    int         cmd;  // 0 none, 1 run/stop, 2 clear, 3 lap
    logic [7:0] f;
    sb_t        item;
    @(posedge clk);
    pcount++;
    #1;
    rst               = r;
    bus.i_btn_runstop = rs;
    bus.i_btn_clear   = cl;
    bus.i_rx_valid    = rxv;
    bus.i_rx_data     = d;
    bus.i_msec        = t_ms;
    bus.i_sec         = t_s;
    bus.i_min         = t_m;
    bus.i_hour        = t_h;

    e   = '0;
    cmd = 0;
    if (r) begin
      m_state = 0;
      m_ms = '0; m_s = '0; m_m = '0; m_h = '0;
    end else if (m_state == 2) begin
      m_state = 0;
    end else begin
      if (rs || cl) begin
        cmd    = cl ? 2 : 1;
        e.drop = rxv;
      end else if (rxv) begin
        f = d | 8'h20;
        if (f == 8'h72) cmd = 1;
        else if (f == 8'h63) cmd = 2;
        else if (f == 8'h6c && LapEn) cmd = 3;
        else e.err = 1'b1;
      end
      if (m_state == 0) begin
        if (cmd == 1) m_state = 1;
        else if (cmd == 2) begin
          m_state = 2;
          m_ms = '0; m_s = '0; m_m = '0; m_h = '0;
        end
      end else begin
        if (cmd == 1) m_state = 0;
        else if (cmd == 3) begin
          m_ms = t_ms; m_s = t_s; m_m = t_m; m_h = t_h;
          e.lapv = 1'b1;
        end
      end
    end
    e.run   = (m_state == 1);
    e.clr   = (m_state == 2);
    e.state = 2'(m_state);
    e.ms = m_ms; e.s = m_s; e.m = m_m; e.h = m_h;
    item.due = pcount + 1;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: compare DUT outputs against the entry due this cycle.
  always @(negedge clk) begin
    obs_t act;
    sb_t  item;
    ncyc++;
    act = {bus.o_run, bus.o_clr, bus.o_state, bus.o_cmd_err, bus.o_cmd_drop,
           bus.o_lap_valid, bus.o_lap_msec, bus.o_lap_sec, bus.o_lap_min, bus.o_lap_hour};
    if (sb_q.size() > 0 && sb_q[0].due < ncyc) begin
      item = sb_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard stale entry due=%0d now=%0d", item.due, ncyc);
    end
    if (sb_q.size() > 0 && sb_q[0].due == ncyc) begin
      item = sb_q.pop_front();
      n_checks++;
      if (act !== item.exp) begin
        n_errors++;
        $display("FAIL outputs cyc=%0d got=%h want=%h (run clr st err drop lapv ms s m h)",
                 ncyc, act, item.exp);
      end
    end
  end

  initial begin
    logic [7:0] chars [8];
    int         k;
    chars[0] = 8'h52; chars[1] = 8'h72; chars[2] = 8'h43; chars[3] = 8'h63;
    chars[4] = 8'h4C; chars[5] = 8'h6C; chars[6] = 8'h58; chars[7] = 8'h00;

    rst = 1'b1;
    bus.i_btn_runstop = 1'b0;
    bus.i_btn_clear   = 1'b0;
    bus.i_rx_valid    = 1'b0;
    bus.i_rx_data     = 8'h00;
    bus.i_msec = '0; bus.i_sec = '0; bus.i_min = '0; bus.i_hour = '0;

    // Directed sequence.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    while (pcount < 9) idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // cycle 10: run
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h72);  // 'r': stop
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);  // clear from stop
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // run
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);  // clear ignored in run
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // stop
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h43);  // button wins, byte dropped
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h58);  // 'X': error
    idle(1);
    t_h = 5'd1; t_m = 6'd23; t_s = 6'd45; t_ms = 7'd67;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h4C);  // lap in run
    t_h = '0; t_m = '0; t_s = '0; t_ms = '0;
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // stop
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);  // clear zeroes lap
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h52);  // ignored during clear cycle
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);  // both buttons -> clear
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);  // run
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);  // reset while running
    idle(2);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      t_ms = 7'($urandom_range(0, 99));
      t_s  = 6'($urandom_range(0, 59));
      t_m  = 6'($urandom_range(0, 59));
      t_h  = 5'($urandom_range(0, 23));
      k = $urandom_range(0, 7);
      if (k == 7) chars[7] = 8'($urandom_range(0, 255));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, chars[k]);
    end
    idle(1);
    repeat (3) @(posedge clk);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
